seven_segment_scanner: RTL and testbench



---
 rtl/seven_segment_scanner_if.sv | 23 ++
 rtl/seven_segment_scanner.sv | 142 ++++++++++++++
 tb/tb_seven_segment_scanner.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/seven_segment_scanner_if.sv
// Display-side bundle for seven_segment_scanner: capture inputs plus registered pin outputs.
interface seven_segment_scanner_if #(
  parameter int DIGITS = 4
);
  logic                  load;
  logic [4*DIGITS-1:0]   value;
  logic [DIGITS-1:0]     dp_in;
  logic                  blank;
  logic [6:0]            seg;
  logic                  dp_n;
  logic [DIGITS-1:0]     an;
  logic                  frame_done;

  modport master (
    output load, value, dp_in, blank,
    input  seg, dp_n, an, frame_done
  );

  modport slave (
    input  load, value, dp_in, blank,
    output seg, dp_n, an, frame_done
  );
endinterface

// File: rtl/seven_segment_scanner.sv
// Time-multiplexed common-anode seven-segment driver with frame-coherent display register.
// Optional leading-zero blanking is enabled by defining SEVENSEG_LZB_EN.
module seven_segment_scanner #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 50000
) (
  input  logic clk,
  input  logic rst,
  seven_segment_scanner_if.slave bus
);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  logic [CNT_W-1:0]    cnt_p0;
  logic [IDX_W-1:0]    idx_p0;
  logic [4*DIGITS-1:0] pend_val_p0;
  logic [DIGITS-1:0]   pend_dp_p0;
  logic [4*DIGITS-1:0] disp_val_p0;
  logic [DIGITS-1:0]   disp_dp_p0;

  logic tc;
  logic wrap;

  assign tc   = (cnt_p0 == CNT_LAST);
  assign wrap = tc && (idx_p0 == IDX_LAST);

  // Stage p0: scan position and two-stage (pending -> display) data storage
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_p0      <= '0;
      idx_p0      <= '0;
      pend_val_p0 <= '0;
      pend_dp_p0  <= '0;
      disp_val_p0 <= '0;
      disp_dp_p0  <= '0;
    end else begin
      if (tc) begin
        cnt_p0 <= '0;
        idx_p0 <= wrap ? '0 : idx_p0 + IDX_W'(1);
      end else begin
        cnt_p0 <= cnt_p0 + CNT_W'(1);
      end
      if (bus.load) begin
        pend_val_p0 <= bus.value;
        pend_dp_p0  <= bus.dp_in;
      end
      // A load landing on the wrap edge bypasses pending so it joins the new frame.
      if (wrap) begin
        disp_val_p0 <= bus.load ? bus.value : pend_val_p0;
        disp_dp_p0  <= bus.load ? bus.dp_in : pend_dp_p0;
      end
    end
  end

  logic [3:0]        sel_nib;
  logic              sel_dp;
  logic [DIGITS-1:0] sel_an;
  logic              suppress;
`ifdef SEVENSEG_LZB_EN
  logic              zero_run;
`endif

  always_comb begin
    sel_nib  = 4'h0;
    sel_dp   = 1'b0;
    sel_an   = '1;
    suppress = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_p0 == IDX_W'(i)) begin
        sel_nib   = disp_val_p0[4*i +: 4];
        sel_dp    = disp_dp_p0[i];
        sel_an[i] = 1'b0;
      end
    end
`ifdef SEVENSEG_LZB_EN
    // Walk down from the top digit; a digit is dark only while everything above it is zero too.
    zero_run = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      zero_run = zero_run && (disp_val_p0[4*i +: 4] == 4'h0) && !disp_dp_p0[i];
      if (idx_p0 == IDX_W'(i)) begin
        suppress = zero_run;
      end
    end
`endif
  end

  logic [DIGITS-1:0] an_p1;
  logic [6:0]        seg_p1;
  logic              dpn_p1;
  logic              fd_p1;

  // Stage p1: registered pin drivers
  always_ff @(posedge clk) begin
    if (rst) begin
      an_p1  <= '1;
      seg_p1 <= 7'h7F;
      dpn_p1 <= 1'b1;
      fd_p1  <= 1'b0;
    end else begin
      fd_p1 <= wrap;
      if (bus.blank || suppress) begin
        an_p1  <= '1;
        seg_p1 <= 7'h7F;
        dpn_p1 <= 1'b1;
      end else begin
        an_p1  <= sel_an;
        seg_p1 <= hex_to_seg(sel_nib);
        dpn_p1 <= ~sel_dp;
      end
    end
  end

  assign bus.an         = an_p1;
  assign bus.seg        = seg_p1;
  assign bus.dp_n       = dpn_p1;
  assign bus.frame_done = fd_p1;
endmodule

// File: tb/tb_seven_segment_scanner.sv
// Randomised bench for seven_segment_scanner (DIGITS=4, REFRESH_DIV=4) against a timeline reference model.
module tb_seven_segment_scanner;
  localparam int D     = 4;
  localparam int RD    = 4;
  localparam int FRAME = D * RD;

  localparam logic [6:0] SEG_TBL [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seven_segment_scanner_if #(.DIGITS(D)) bus ();

  seven_segment_scanner #(.DIGITS(D), .REFRESH_DIV(RD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int nvec = 0;
  int nerr = 0;

  // Reference model: k = edges since reset release; data in hex words.
  int          k = 0;
  logic [15:0] m_pend_v  = '0;
  logic [3:0]  m_pend_d  = '0;
  logic [15:0] m_shown_v = '0;
  logic [3:0]  m_shown_d = '0;
  logic [3:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_dpn;
  logic        e_fd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s at k=%0d: got %0h expected %0h", tag, k, got, exp);
    end
  endtask

  task automatic model_edge(input logic r, input logic ld, input logic [15:0] v,
                            input logic [3:0] d, input logic bl);
    int  di;
    bit  dark;
    if (r) begin
      k = 0;
      m_pend_v = '0; m_pend_d = '0; m_shown_v = '0; m_shown_d = '0;
      e_an = 4'hF; e_seg = 7'h7F; e_dpn = 1'b1; e_fd = 1'b0;
      return;
    end
    k++;
    di   = ((k - 1) / RD) % D;
    dark = bl;
`ifdef SEVENSEG_LZB_EN
    if (di > 0) begin
      bit allz = 1'b1;
      for (int j = di; j < D; j++)
        if (m_shown_v[4*j +: 4] != 4'h0 || m_shown_d[j]) allz = 1'b0;
      if (allz) dark = 1'b1;
    end
`endif
    if (dark) begin
      e_an = 4'hF; e_seg = 7'h7F; e_dpn = 1'b1;
    end else begin
      e_an  = ~(4'b0001 << di);
      e_seg = SEG_TBL[m_shown_v[4*di +: 4]];
      e_dpn = ~m_shown_d[di];
    end
    e_fd = (k % FRAME == 0);
    if (k % FRAME == 0) begin
      m_shown_v = ld ? v : m_pend_v;
      m_shown_d = ld ? d : m_pend_d;
    end
    if (ld) begin
      m_pend_v = v;
      m_pend_d = d;
    end
  endtask

  // Called at a negedge; applies inputs, clocks once, checks #1 after the edge, returns at next negedge.
  task automatic step(input logic r, input logic ld, input logic [15:0] v,
                      input logic [3:0] d, input logic bl);
    rst = r; bus.load = ld; bus.value = v; bus.dp_in = d; bus.blank = bl;
    @(posedge clk);
    model_edge(r, ld, v, d, bl);
    #1;
    check("an",         {28'd0, bus.an},       {28'd0, e_an});
    check("seg",        {25'd0, bus.seg},      {25'd0, e_seg});
    check("dp_n",       {31'd0, bus.dp_n},     {31'd0, e_dpn});
    check("frame_done", {31'd0, bus.frame_done}, {31'd0, e_fd});
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0, 4'h0, 1'b0);
  endtask

  task automatic load_now(input logic [15:0] v, input logic [3:0] d);
    step(1'b0, 1'b1, v, d, 1'b0);
  endtask

  // Advance until the next edge is the wrap edge (bounded by one frame).
  task automatic to_pre_wrap();
    for (int i = 0; i < FRAME && ((k + 1) % FRAME != 0); i++) idle(1);
  endtask

  initial begin
    logic        bl;
    logic [15:0] v;
    logic [3:0]  d;
    bus.load = 1'b0; bus.value = '0; bus.dp_in = '0; bus.blank = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 16'h0, 4'h0, 1'b0);
    // Load with rst is ignored
    step(1'b1, 1'b1, 16'hFFFF, 4'hF, 1'b0);
    idle(2 * FRAME);

    load_now(16'h12AF, 4'h0);
    idle(2 * FRAME + 3);

    // Mid-frame load during digit 1
    to_pre_wrap();
    idle(RD + 2);
    load_now(16'h8888, 4'h0);
    idle(FRAME);
    // Load exactly on the wrap edge
    to_pre_wrap();
    load_now(16'h3333, 4'h0);
    idle(FRAME);

    // Blank burst mid-digit
    idle(2);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 16'h0, 4'h0, 1'b1);
    idle(FRAME);

    // Leading-zero patterns (all lit when blanking is compiled out)
    load_now(16'h0050, 4'h0);
    idle(2 * FRAME);
    load_now(16'h0005, 4'b0100);
    idle(2 * FRAME);
    load_now(16'h0000, 4'h0);
    idle(2 * FRAME);

    // 1-cycle reset while digit 2 is lit
    to_pre_wrap();
    idle(2 * RD + 2);
    step(1'b1, 1'b0, 16'h0, 4'h0, 1'b0);
    idle(FRAME + 4);

    // Randomised phase
    bl = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 24) == 0) bl = ~bl;
      v = 16'($urandom >> (16 + 4 * $urandom_range(0, 4)));
      d = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      step(($urandom_range(0, 499) == 0), ($urandom_range(0, 19) == 0), v, d, bl);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
